reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Parametrised register-hazard tracker for the pipelined datapath.
- Replaces fixed per-stage compare logic with a per-register pending/countdown table, so it supports producers of variable latency (ALU 1, load 2, multi-cycle mul/div up to MAX_LAT) and NRD read ports.
- Sits beside decode: it receives accepted issues, writebacks and a kill (flushEX equivalent), and produces the decode stall plus per-port forward-ready flags.

Parameters:
- NREGS, 32, number of architectural registers; register 0 is hardwired and never pending.
- AW, 5, register address width; NREGS <= 2**AW.
- NRD, 2, number of decode read ports.
- MAX_LAT, 7, largest issue latency (cycles until the result is forwardable).
- LW, 3, countdown width; MAX_LAT <= 2**LW-1.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- rd_addr  in  NRD*AW  decode source register addresses; port i = bits [i*AW +: AW]
- rd_used  in  NRD  port i source is actually consumed
- issue_valid  in  1  decode wants to issue an instruction
- issue_we  in  1  issuing instruction writes a register
- issue_dst  in  AW  destination register
- issue_lat  in  LW  cycles until the result is forwardable, 1..MAX_LAT
- kill  in  1  squash the instruction accepted in the previous cycle
- wb_valid  in  1  writeback occurring this cycle
- wb_dst  in  AW  writeback register
- stall  out  1  decode must hold (stallFE/stallID)
- issue_accept  out  1  issue_valid & ~stall
- fwd_ready  out  NRD  port i source is pending but forwardable from the pipeline
- pending_cnt  out  AW+1  number of registers currently pending

Behaviour:
- State per register r (1..NREGS-1): pend[r], cnt[r] (LW bits). A last-issue record holds last_v, last_dst, last_prev_pend and last_prev_cnt.
- Reset (async): all pend=0, cnt=0, last_v=0. Outputs: stall=0, issue_accept=0 (issue_valid=0 assumed), fwd_ready=0, pending_cnt=0.
- Hit on port i: rd_used[i] & rd_addr_i!=0 & pend[rd_addr_i].
- stall = OR over ports of (hit_i & cnt[rd_addr_i]!=0). Combinational from state and rd inputs; zero latency.
- fwd_ready[i] = hit_i & cnt==0.
- Per-clock update order, applied in this sequence, last write wins:
  1. Countdown: every pend entry with cnt>0 decrements by 1; it saturates at 0.
  2. Writeback: wb_valid & wb_dst!=0 clears pend[wb_dst] and sets cnt to 0.
  3. Kill: kill & last_v restores pend[last_dst] and cnt[last_dst] to last_prev_pend/last_prev_cnt. If a writeback to the same register occurs in the same cycle, the restored state has pend cleared.
  4. Issue: issue_accept & issue_we & issue_dst!=0 sets pend[issue_dst]=1 and cnt=issue_lat-1. last_v=1, last_dst=issue_dst, and last_prev_* capture the state after steps 1-3. Otherwise last_v=0.
- Issue and kill in the same cycle: the kill applies to the older instruction first; then the new issue records normally.
- Issue and writeback to the same register in the same cycle: the issue wins and the register stays pending (WAW).
- issue_lat=0 is treated as 1. Values above MAX_LAT are clamped to MAX_LAT.
- A stalled issue (issue_valid & stall) leaves the table unchanged apart from the countdown.
- Writes to register 0 are ignored everywhere. Reads of register 0 never hit.
- pending_cnt is registered: it reflects the pend popcount after the clock edge.
- Reset mid-operation clears everything immediately. The first cycle after reset release behaves as an empty table.

Decomposition:
- Shared package: AW, NREGS, LW, the latency constants (LAT_ALU=1, LAT_LOAD=2, LAT_MUL=4, LAT_DIV=MAX_LAT) and the REG_ZERO constant.
- One sub-module: sb_entry. It is one register's pend/cnt flop pair with decrement, clear, restore and set inputs, and is instantiated NREGS-1 times by generate. The top-level block holds the port compares, the last-issue record and the popcount.

Test Plan:
- Load-use: issue dst=5, lat=2. Next cycle rd_addr0=5 used: stall=1 for 1 cycle, then stall=0 and fwd_ready[0]=1. After wb_dst=5, fwd_ready[0]=0 and pending_cnt returns to 0.
- Long op: issue dst=9, lat=7. Reader on port 1 with rd_addr=9: stall=1 for exactly 6 cycles and issue_accept=0 throughout. Then fwd_ready[1]=1.
- Kill: register 3 idle. Issue dst=3, lat=4, then kill next cycle: pend[3]=0 and a reader of 3 does not stall. Repeat with 3 previously pending (cnt=2): after the kill, 3 is still pending with cnt restored and decremented correctly.
- Same-cycle events: wb_dst=7 and issue dst=7 together: 7 stays pending with cnt=lat-1. wb plus kill on the same register: 7 ends not pending.
- Register 0 and rd_used: issue dst=0 gives pending_cnt=0. rd_addr=0 never stalls. A pending register with rd_used=0 gives stall=0.
- Async reset: with 4 registers pending and stall=1, pulse reset between edges. stall, fwd_ready and pending_cnt drop to 0 immediately, and the next accepted issue sees an empty table.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register-hazard scoreboard: table geometry,
// producer latencies and the hardwired zero register.
package reg_scoreboard_pkg;

    localparam int NREGS   = 32;
    localparam int AW      = 5;
    localparam int NRD     = 2;
    localparam int MAX_LAT = 7;
    localparam int LW      = 3;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;
    localparam int LAT_MUL  = 4;
    localparam int LAT_DIV  = MAX_LAT;

    localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// One register's pending flag and forwarding countdown. The mid_* outputs expose
// the state after countdown/writeback/kill so the issue record can snapshot it.
module sb_entry #(
    parameter int LW = reg_scoreboard_pkg::LW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          dec,
    input  logic          clr,
    input  logic          restore,
    input  logic          restore_pend,
    input  logic [LW-1:0] restore_cnt,
    input  logic          set,
    input  logic [LW-1:0] set_cnt,
    output logic          pend,
    output logic [LW-1:0] cnt,
    output logic          mid_pend,
    output logic [LW-1:0] mid_cnt
);

    // Later steps override earlier ones: countdown, writeback, kill restore.
    always_comb begin
        mid_pend = pend;
        mid_cnt  = cnt;
        if (dec && pend && cnt != '0)
            mid_cnt = cnt - LW'(1);
        if (clr) begin
            mid_pend = 1'b0;
            mid_cnt  = '0;
        end
        if (restore) begin
            mid_pend = restore_pend & ~clr;
            mid_cnt  = clr ? '0 : restore_cnt;
        end
    end

    // NOTE: state flops use non-blocking assignments so every entry samples
    // the same pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend <= 1'b0;
            cnt  <= '0;
        end else if (set) begin
            pend <= 1'b1;
            cnt  <= set_cnt;
        end else begin
            pend <= mid_pend;
            cnt  <= mid_cnt;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-hazard tracker beside decode: per-register pending/countdown table,
// decode stall, per-port forward-ready flags and a one-deep kill undo record.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREGS   = reg_scoreboard_pkg::NREGS,
    parameter int AW      = reg_scoreboard_pkg::AW,
    parameter int NRD     = reg_scoreboard_pkg::NRD,
    parameter int MAX_LAT = reg_scoreboard_pkg::MAX_LAT,
    parameter int LW      = reg_scoreboard_pkg::LW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    rd_used,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [AW-1:0]     issue_dst,
    input  logic [LW-1:0]     issue_lat,
    input  logic              kill,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_dst,
    output logic              stall,
    output logic              issue_accept,
    output logic [NRD-1:0]    fwd_ready,
    output logic [AW:0]       pending_cnt
);

    // Table padded to the full address space so any read address indexes safely.
    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] mid_pend;
    logic [DEPTH-1:0] nxt_pend;
    logic [LW-1:0]    cnt     [DEPTH];
    logic [LW-1:0]    mid_cnt [DEPTH];

    logic          last_v;
    logic [AW-1:0] last_dst;
    logic          last_prev_pend;
    logic [LW-1:0] last_prev_cnt;

    logic          wb_hit;
    logic          kill_hit;
    logic          set_hit;
    logic [LW-1:0] lat_eff;
    logic [LW-1:0] set_cnt;
    logic [AW:0]   pop;

    logic [AW-1:0]  port_addr [NRD];
    logic [NRD-1:0] hit;
    logic [NRD-1:0] busy;

    for (genvar i = 0; i < NRD; i++) begin : g_port
        assign port_addr[i] = rd_addr[i*AW +: AW];
        assign hit[i]       = rd_used[i] && (port_addr[i] != AW'(REG_ZERO)) && pend[port_addr[i]];
        assign busy[i]      = hit[i] && (cnt[port_addr[i]] != '0);
        assign fwd_ready[i] = hit[i] && (cnt[port_addr[i]] == '0);
    end

    assign stall        = |busy;
    assign issue_accept = issue_valid & ~stall;

    assign wb_hit   = wb_valid && (wb_dst != AW'(REG_ZERO));
    assign kill_hit = kill && last_v;
    assign set_hit  = issue_accept && issue_we && (issue_dst != AW'(REG_ZERO));

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else leaves it unassigned and infers a latch.
    always_comb begin
        lat_eff = issue_lat;
        if (issue_lat == '0)
            lat_eff = LW'(1);
        else if (int'(issue_lat) > MAX_LAT)
            lat_eff = LW'(MAX_LAT);
    end

    assign set_cnt = lat_eff - LW'(1);

    assign pend[0]     = 1'b0;
    assign cnt[0]      = '0;
    assign mid_pend[0] = 1'b0;
    assign mid_cnt[0]  = '0;
    assign nxt_pend[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_entry
        sb_entry #(.LW(LW)) u_entry (
            .clock        (clock),
            .reset        (reset),
            .dec          (1'b1),
            .clr          (wb_hit && (wb_dst == AW'(r))),
            .restore      (kill_hit && (last_dst == AW'(r))),
            .restore_pend (last_prev_pend),
            .restore_cnt  (last_prev_cnt),
            .set          (set_hit && (issue_dst == AW'(r))),
            .set_cnt      (set_cnt),
            .pend         (pend[r]),
            .cnt          (cnt[r]),
            .mid_pend     (mid_pend[r]),
            .mid_cnt      (mid_cnt[r])
        );
        assign nxt_pend[r] = mid_pend[r] | (set_hit && (issue_dst == AW'(r)));
    end

    for (genvar r = NREGS; r < DEPTH; r++) begin : g_unused
        assign pend[r]     = 1'b0;
        assign cnt[r]      = '0;
        assign mid_pend[r] = 1'b0;
        assign mid_cnt[r]  = '0;
        assign nxt_pend[r] = 1'b0;
    end

    // Snapshot of the destination taken after countdown/writeback/kill, so a
    // kill next cycle undoes exactly this issue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_v         <= 1'b0;
            last_dst       <= '0;
            last_prev_pend <= 1'b0;
            last_prev_cnt  <= '0;
        end else begin
            last_v <= set_hit;
            if (set_hit) begin
                last_dst       <= issue_dst;
                last_prev_pend <= mid_pend[issue_dst];
                last_prev_cnt  <= mid_cnt[issue_dst];
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int r = 0; r < DEPTH; r++)
            pop = pop + {{AW{1'b0}}, nxt_pend[r]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pending_cnt <= '0;
        else
            pending_cnt <= pop;
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazard stall, forwarding, kill undo,
// same-cycle event ordering, register 0 and asynchronous reset.
module tb_reg_scoreboard;

    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int LW  = 3;

    logic              clock;
    logic              reset;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD-1:0]    rd_used;
    logic              issue_valid;
    logic              issue_we;
    logic [AW-1:0]     issue_dst;
    logic [LW-1:0]     issue_lat;
    logic              kill;
    logic              wb_valid;
    logic [AW-1:0]     wb_dst;
    logic              stall;
    logic              issue_accept;
    logic [NRD-1:0]    fwd_ready;
    logic [AW:0]       pending_cnt;

    int checks   = 0;
    int failures = 0;

    reg_scoreboard dut (
        .clock        (clock),
        .reset        (reset),
        .rd_addr      (rd_addr),
        .rd_used      (rd_used),
        .issue_valid  (issue_valid),
        .issue_we     (issue_we),
        .issue_dst    (issue_dst),
        .issue_lat    (issue_lat),
        .kill         (kill),
        .wb_valid     (wb_valid),
        .wb_dst       (wb_dst),
        .stall        (stall),
        .issue_accept (issue_accept),
        .fwd_ready    (fwd_ready),
        .pending_cnt  (pending_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        rd_addr     = '0;
        rd_used     = '0;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_dst   = '0;
        issue_lat   = '0;
        kill        = 1'b0;
        wb_valid    = 1'b0;
        wb_dst      = '0;
    endtask

    task automatic issue(input logic [AW-1:0] dst, input logic [LW-1:0] lat);
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_dst   = dst;
        issue_lat   = lat;
    endtask

    task automatic no_issue();
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_dst   = '0;
        issue_lat   = '0;
    endtask

    task automatic writeback(input logic [AW-1:0] dst);
        wb_valid = 1'b1;
        wb_dst   = dst;
        tick();
        wb_valid = 1'b0;
        wb_dst   = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        #7;
        reset = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (fwd_ready !== 2'b00) begin failures++; $display("FAIL reset_fwd got=%b exp=00", fwd_ready); end
        checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", pending_cnt); end
        checks++; if (issue_accept !== 1'b0) begin failures++; $display("FAIL reset_accept got=%b exp=0", issue_accept); end
        tick();
    endtask

    task automatic test_load_use();
        issue(5'd5, 3'd2);
        #1;
        checks++; if (issue_accept !== 1'b1) begin failures++; $display("FAIL lu_accept got=%b exp=1", issue_accept); end
        tick();
        no_issue();
        rd_addr = {5'd0, 5'd5};
        rd_used = 2'b01;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall); end
        checks++; if (fwd_ready !== 2'b00) begin failures++; $display("FAIL lu_fwd_early got=%b exp=00", fwd_ready); end
        checks++; if (pending_cnt !== 6'd1) begin failures++; $display("FAIL lu_pending got=%0d exp=1", pending_cnt); end
        tick();
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall_end got=%b exp=0", stall); end
        checks++; if (fwd_ready !== 2'b01) begin failures++; $display("FAIL lu_fwd got=%b exp=01", fwd_ready); end
        writeback(5'd5);
        checks++; if (fwd_ready !== 2'b00) begin failures++; $display("FAIL lu_fwd_wb got=%b exp=00", fwd_ready); end
        checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL lu_pending_wb got=%0d exp=0", pending_cnt); end
        idle();
    endtask

    task automatic test_long_op();
        int stall_cycles;
        bit done;
        issue(5'd9, 3'd7);
        tick();
        // A dependent writer of r10 keeps trying to issue while stalled.
        issue(5'd10, 3'd1);
        rd_addr = {5'd9, 5'd0};
        rd_used = 2'b10;
        stall_cycles = 0;
        done = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            #1;
            if (stall === 1'b1) begin
                stall_cycles++;
                checks++; if (issue_accept !== 1'b0) begin failures++; $display("FAIL long_accept_cycle%0d got=%b exp=0", k, issue_accept); end
                tick();
            end else begin
                done = 1'b1;
            end
        end
        checks++; if (stall_cycles != 6) begin failures++; $display("FAIL long_stall_len got=%0d exp=6", stall_cycles); end
        checks++; if (fwd_ready !== 2'b10) begin failures++; $display("FAIL long_fwd got=%b exp=10", fwd_ready); end
        checks++; if (issue_accept !== 1'b1) begin failures++; $display("FAIL long_accept_end got=%b exp=1", issue_accept); end
        checks++; if (pending_cnt !== 6'd1) begin failures++; $display("FAIL long_pending got=%0d exp=1", pending_cnt); end
        no_issue();
        writeback(5'd9);
        checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL long_pending_wb got=%0d exp=0", pending_cnt); end
        idle();
    endtask

    task automatic test_kill();
        issue(5'd3, 3'd4);
        tick();
        no_issue();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        rd_addr = {5'd0, 5'd3};
        rd_used = 2'b01;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL kill_idle_stall got=%b exp=0", stall); end
        checks++; if (fwd_ready !== 2'b00) begin failures++; $display("FAIL kill_idle_fwd got=%b exp=00", fwd_ready); end
        checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL kill_idle_pending got=%0d exp=0", pending_cnt); end
        rd_used = 2'b00;
        // r3 pending with cnt=2; the second issue snapshots (1,1) after countdown.
        issue(5'd3, 3'd3);
        tick();
        issue(5'd3, 3'd4);
        tick();
        no_issue();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        rd_used = 2'b01;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL kill_restore_stall got=%b exp=1", stall); end
        checks++; if (pending_cnt !== 6'd1) begin failures++; $display("FAIL kill_restore_pending got=%0d exp=1", pending_cnt); end
        tick();
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL kill_restore_stall_end got=%b exp=0", stall); end
        checks++; if (fwd_ready !== 2'b01) begin failures++; $display("FAIL kill_restore_fwd got=%b exp=01", fwd_ready); end
        writeback(5'd3);
        idle();
    endtask

    task automatic test_same_cycle();
        issue(5'd7, 3'd3);
        wb_valid = 1'b1;
        wb_dst   = 5'd7;
        tick();
        no_issue();
        wb_valid = 1'b0;
        wb_dst   = '0;
        rd_addr = {5'd0, 5'd7};
        rd_used = 2'b01;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL waw_stall got=%b exp=1", stall); end
        checks++; if (pending_cnt !== 6'd1) begin failures++; $display("FAIL waw_pending got=%0d exp=1", pending_cnt); end
        tick();
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL waw_stall2 got=%b exp=1", stall); end
        tick();
        checks++; if (fwd_ready !== 2'b01) begin failures++; $display("FAIL waw_fwd got=%b exp=01", fwd_ready); end
        // r7 pending with cnt=0; reissue, then kill and writeback together.
        issue(5'd7, 3'd2);
        #1;
        checks++; if (issue_accept !== 1'b1) begin failures++; $display("FAIL wbkill_accept got=%b exp=1", issue_accept); end
        tick();
        no_issue();
        kill     = 1'b1;
        wb_valid = 1'b1;
        wb_dst   = 5'd7;
        tick();
        idle();
        rd_addr = {5'd0, 5'd7};
        rd_used = 2'b01;
        #1;
        checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL wbkill_pending got=%0d exp=0", pending_cnt); end
        checks++; if (stall !== 1'b0 || fwd_ready !== 2'b00) begin failures++; $display("FAIL wbkill_read got=%b/%b exp=0/00", stall, fwd_ready); end
        idle();
    endtask

    task automatic test_reg_zero();
        issue(5'd0, 3'd3);
        #1;
        checks++; if (issue_accept !== 1'b1) begin failures++; $display("FAIL zero_accept got=%b exp=1", issue_accept); end
        tick();
        no_issue();
        rd_addr = {5'd0, 5'd0};
        rd_used = 2'b11;
        #1;
        checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL zero_pending got=%0d exp=0", pending_cnt); end
        checks++; if (stall !== 1'b0 || fwd_ready !== 2'b00) begin failures++; $display("FAIL zero_read got=%b/%b exp=0/00", stall, fwd_ready); end
        rd_used = 2'b00;
        issue(5'd12, 3'd5);
        tick();
        no_issue();
        rd_addr = {5'd0, 5'd12};
        #1;
        checks++; if (stall !== 1'b0 || fwd_ready !== 2'b00) begin failures++; $display("FAIL unused_read got=%b/%b exp=0/00", stall, fwd_ready); end
        rd_used = 2'b01;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL used_read got=%b exp=1", stall); end
        rd_used = 2'b00;
        // Latency 0 behaves as 1: forwardable on the very next cycle.
        issue(5'd14, 3'd0);
        tick();
        no_issue();
        rd_addr = {5'd14, 5'd0};
        rd_used = 2'b10;
        #1;
        checks++; if (stall !== 1'b0 || fwd_ready !== 2'b10) begin failures++; $display("FAIL lat0_read got=%b/%b exp=0/10", stall, fwd_ready); end
        checks++; if (pending_cnt !== 6'd2) begin failures++; $display("FAIL lat0_pending got=%0d exp=2", pending_cnt); end
        writeback(5'd12);
        writeback(5'd14);
        checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL zero_cleanup got=%0d exp=0", pending_cnt); end
        idle();
    endtask

    task automatic test_async_reset();
        issue(5'd1, 3'd5); tick();
        issue(5'd2, 3'd5); tick();
        issue(5'd4, 3'd5); tick();
        issue(5'd8, 3'd5); tick();
        no_issue();
        rd_addr = {5'd2, 5'd8};
        rd_used = 2'b11;
        #1;
        checks++; if (pending_cnt !== 6'd4) begin failures++; $display("FAIL ar_pending_pre got=%0d exp=4", pending_cnt); end
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ar_stall_pre got=%b exp=1", stall); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ar_stall got=%b exp=0", stall); end
        checks++; if (fwd_ready !== 2'b00) begin failures++; $display("FAIL ar_fwd got=%b exp=00", fwd_ready); end
        checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL ar_pending got=%0d exp=0", pending_cnt); end
        reset = 1'b0;
        issue(5'd2, 3'd2);
        #1;
        checks++; if (stall !== 1'b0 || issue_accept !== 1'b1) begin failures++; $display("FAIL ar_first_issue got=%b/%b exp=0/1", stall, issue_accept); end
        tick();
        no_issue();
        rd_addr = {5'd0, 5'd2};
        rd_used = 2'b01;
        #1;
        checks++; if (pending_cnt !== 6'd1) begin failures++; $display("FAIL ar_pending_post got=%0d exp=1", pending_cnt); end
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ar_stall_post got=%b exp=1", stall); end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_long_op();
        test_kill();
        test_same_cycle();
        test_reg_zero();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
